// File: rtl/ex_pkg.sv
// ex_pkg: op codes, MD FSM states and helpers shared by the execute stage.
package ex_pkg;
  typedef enum logic [5:0] {
    OP_NOP, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_LUI,
    OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_MEM, OP_LINK,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
    OP_ADD, OP_ADDI, OP_SUB
  } op_e;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;
  localparam int LINK_OFS = 8;
  function automatic logic md_op(input logic [5:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
  endfunction
  function automatic logic md_start_op(input logic [5:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction
endpackage

// File: rtl/ex_md_unit.sv
// ex_md_unit: multi-cycle multiply/divide with HI/LO registers and a read bypass
// so a reader waiting on the completing cycle sees the fresh result.
module ex_md_unit
  import ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mt_we,
  input  logic              mt_sel,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1);
  md_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [5:0] r_op;
  logic [DATA_W-1:0] r_a, r_b, r_hi, r_lo, w_hi, w_lo, w_ua, w_ub, w_q, w_r;
  logic [2*DATA_W-1:0] w_prod;
  logic w_sgn, w_div, w_sa, w_sb, w_wr;
  assign busy = r_state == MD_BUSY;
  assign done = busy && r_cnt == CW'(1);
  assign w_wr = done && !(w_div && r_b == '0);
  assign hi = w_wr ? w_hi : r_hi;
  assign lo = w_wr ? w_lo : r_lo;
  // Signed divide goes through magnitudes, so most-negative / -1 wraps without a special case.
  always_comb begin
    w_sgn = r_op inside {OP_MULT, OP_DIV};
    w_div = r_op inside {OP_DIV, OP_DIVU};
    w_sa = w_sgn & r_a[DATA_W-1];
    w_sb = w_sgn & r_b[DATA_W-1];
    w_prod = {{DATA_W{w_sa}}, r_a} * {{DATA_W{w_sb}}, r_b};
    w_ua = w_sa ? -r_a : r_a;
    w_ub = w_sb ? -r_b : r_b;
    w_q = w_ub == '0 ? '0 : w_ua / w_ub;
    w_r = w_ub == '0 ? '0 : w_ua % w_ub;
    w_hi = w_div ? (w_sa ? -w_r : w_r) : w_prod[2*DATA_W-1:DATA_W];
    w_lo = w_div ? (w_sa ^ w_sb ? -w_q : w_q) : w_prod[DATA_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_cnt <= '0;
      r_op <= '0;
      r_a <= '0;
      r_b <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_wr) begin
        r_hi <= w_hi;
        r_lo <= w_lo;
      end
      if (mt_we && mt_sel) r_hi <= a;
      if (mt_we && !mt_sel) r_lo <= a;
      if (start) begin
        r_state <= MD_BUSY;
        r_cnt <= op inside {OP_DIV, OP_DIVU} ? CW'(DIV_LAT) : CW'(MUL_LAT);
        r_op <= op;
        r_a <= a;
        r_b <= b;
      end else if (busy) begin
        r_cnt <= r_cnt - CW'(1);
        if (done) r_state <= MD_IDLE;
      end
    end
endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md: MIPS execute stage with N-way forwarding, EX/MEM register and MD unit.
// Define EX_OVF_EXC_EN to trap signed overflow on ADD/ADDI/SUB via out_ovf.
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FWD_N   = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_pc,
  input  logic [31:0]                in_instr,
  input  logic [5:0]                 in_op,
  input  logic [DATA_W-1:0]          in_rs_data,
  input  logic [DATA_W-1:0]          in_rt_data,
  input  logic [DATA_W-1:0]          in_imm,
  input  logic [$clog2(FWD_N+1)-1:0] fwd_rs_sel,
  input  logic [$clog2(FWD_N+1)-1:0] fwd_rt_sel,
  input  logic [FWD_N*DATA_W-1:0]    fwd_data,
  input  logic                       flush,
  output logic                       stall_out,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_pc,
  output logic [31:0]                out_instr,
  output logic [5:0]                 out_op,
  output logic [DATA_W-1:0]          out_result,
  output logic [DATA_W-1:0]          out_rt_data
`ifdef EX_OVF_EXC_EN
  , output logic                     out_ovf
`endif
);
  localparam int SW = $clog2(FWD_N + 1);
  localparam int M = DATA_W - 1;
  logic [DATA_W-1:0] w_rs, w_rt, w_b, w_sum, w_dif, w_res, w_hi, w_lo;
  logic [4:0] w_sh;
  logic w_busy, w_done, w_accept;
  assign stall_out = in_valid & ~flush & md_op(in_op) & w_busy & ~w_done;
  assign w_accept = in_valid & ~flush & ~stall_out;
  // Out-of-range selects fall through to zero.
  always_comb begin
    w_rs = fwd_rs_sel == '0 ? in_rs_data : '0;
    w_rt = fwd_rt_sel == '0 ? in_rt_data : '0;
    for (int k = 1; k <= FWD_N; k++) begin
      if (fwd_rs_sel == SW'(k)) w_rs = fwd_data[(k-1)*DATA_W +: DATA_W];
      if (fwd_rt_sel == SW'(k)) w_rt = fwd_data[(k-1)*DATA_W +: DATA_W];
    end
    w_b = in_op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_MEM, OP_LUI, OP_ADDI}
        ? in_imm : w_rt;
    w_sh = in_op inside {OP_SLLV, OP_SRLV, OP_SRAV} ? w_rs[4:0] : in_instr[10:6];
    w_sum = w_rs + w_b;
    w_dif = w_rs - w_b;
    case (in_op)
      OP_ADDU, OP_ADDIU, OP_MEM, OP_ADD, OP_ADDI: w_res = w_sum;
      OP_SUBU, OP_SUB:    w_res = w_dif;
      OP_AND, OP_ANDI:    w_res = w_rs & w_b;
      OP_OR, OP_ORI:      w_res = w_rs | w_b;
      OP_XOR, OP_XORI:    w_res = w_rs ^ w_b;
      OP_NOR:             w_res = ~(w_rs | w_b);
      OP_SLT, OP_SLTI:    w_res = DATA_W'($signed(w_rs) < $signed(w_b));
      OP_SLTU, OP_SLTIU:  w_res = DATA_W'(w_rs < w_b);
      OP_SLL, OP_SLLV:    w_res = w_rt << w_sh;
      OP_SRL, OP_SRLV:    w_res = w_rt >> w_sh;
      OP_SRA, OP_SRAV:    w_res = $signed(w_rt) >>> w_sh;
      OP_LUI:             w_res = w_b << 16;
      OP_LINK:            w_res = in_pc + DATA_W'(LINK_OFS);
      OP_MFHI:            w_res = w_hi;
      OP_MFLO:            w_res = w_lo;
      default:            w_res = '0;
    endcase
  end
`ifdef EX_OVF_EXC_EN
  logic w_ovf;
  assign w_ovf = in_op inside {OP_ADD, OP_ADDI} ? (w_rs[M] == w_b[M] && w_sum[M] != w_rs[M])
               : in_op == OP_SUB ? (w_rs[M] != w_b[M] && w_dif[M] != w_rs[M]) : 1'b0;
`endif
  ex_md_unit #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_md (
    .clk(clk),
    .rst_n(rst_n),
    .start(w_accept & md_start_op(in_op)),
    .op(in_op),
    .a(w_rs),
    .b(w_rt),
    .mt_we(w_accept & (in_op inside {OP_MTHI, OP_MTLO})),
    .mt_sel(in_op == OP_MTHI),
    .hi(w_hi),
    .lo(w_lo),
    .busy(w_busy),
    .done(w_done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_instr <= '0;
      out_op <= '0;
      out_result <= '0;
      out_rt_data <= '0;
`ifdef EX_OVF_EXC_EN
      out_ovf <= 1'b0;
`endif
    end else if (stall_out) out_valid <= 1'b0;
    else begin
      out_valid <= in_valid & ~flush;
      out_pc <= in_pc;
      out_instr <= in_instr;
      out_result <= w_res;
      out_rt_data <= w_rt;
`ifdef EX_OVF_EXC_EN
      out_op <= w_ovf ? 6'(OP_NOP) : in_op;
      out_ovf <= w_ovf;
`else
      out_op <= in_op;
`endif
    end
endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed vectors with hand-computed results for ex_stage_md.
module tb_ex_stage_md;
  import ex_pkg::*;
  typedef struct packed {
    op_e op;
    logic [31:0] rs, rt, imm, instr, exp;
  } vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, flush = 0;
  logic [31:0] in_pc = 0, in_instr = 0, in_rs_data = 0, in_rt_data = 0, in_imm = 0;
  logic [5:0] in_op = 0;
  logic [1:0] fwd_rs_sel = 0, fwd_rt_sel = 0;
  logic [63:0] fwd_data = 0;
  logic stall_out, out_valid;
  logic [31:0] out_pc, out_instr, out_result, out_rt_data;
  logic [5:0] out_op;
  int checks = 0, errors = 0, n;
  vec_t vecs[10];
  always #5 clk = ~clk;
  ex_stage_md dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_op(in_op), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .fwd_data(fwd_data), .flush(flush),
    .stall_out(stall_out), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_op(out_op), .out_result(out_result), .out_rt_data(out_rt_data)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input op_e op, input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm);
    in_valid = 1;
    in_op = op;
    in_rs_data = rs;
    in_rt_data = rt;
    in_imm = imm;
    in_pc = 0;
    in_instr = 0;
    fwd_rs_sel = 0;
    fwd_rt_sel = 0;
    flush = 0;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_free(output int cnt);
    cnt = 0;
    #1;
    while (stall_out && cnt < 40) begin
      step;
      cnt++;
    end
    chk("stall_bound", 32'(stall_out), 0);
  endtask
  initial begin
    vecs = '{
      '{OP_SUBU, 32'd3, 32'd5, 32'd0, 32'h0, 32'hFFFF_FFFE},
      '{OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 32'd1},
      '{OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 32'd0},
      '{OP_SRA, 32'd0, 32'h8000_0000, 32'd0, 32'h100, 32'hF800_0000},
      '{OP_SRLV, 32'h24, 32'h8000_0000, 32'd0, 32'h0, 32'h0800_0000},
      '{OP_LUI, 32'd0, 32'd0, 32'h1234, 32'h0, 32'h1234_0000},
      '{OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'd0, 32'h0, 32'h0000_000F},
      '{OP_SLL, 32'd0, 32'h12, 32'd0, 32'h200, 32'h1200},
      '{OP_ADDU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h0, 32'd1},
      '{OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h0, 32'h8000_0000}
    };
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_result", out_result, 0);
    chk("rst_stall", 32'(stall_out), 0);
    @(negedge clk) rst_n = 1;
    fwd_data = {32'h100, 32'h10};
    drive(OP_ADDU, 0, 5, 0); fwd_rs_sel = 1; step;
    chk("fwd_rs1", out_result, 32'h15);
    chk("fwd_valid", 32'(out_valid), 1);
    chk("fwd_op", 32'(out_op), 32'(OP_ADDU));
    drive(OP_ADDU, 0, 5, 0); fwd_rs_sel = 3; step;
    chk("fwd_rs_oob", out_result, 32'h5);
    drive(OP_ADDU, 3, 7, 0); fwd_rt_sel = 2; step;
    chk("fwd_rt2", out_result, 32'h103);
    chk("fwd_rt_data", out_rt_data, 32'h100);
    drive(OP_ADDIU, 0, 7, 32'hFFFF_FFFF); fwd_rs_sel = 1; step;
    chk("imm_after_fwd", out_result, 32'hF);
    chk("imm_rt_data", out_rt_data, 32'h7);
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].imm); in_instr = vecs[i].instr; step;
      chk($sformatf("alu%0d", i), out_result, vecs[i].exp);
    end
    drive(OP_LINK, 0, 0, 0); in_pc = 32'h0040_3000; step;
    chk("jal_result", out_result, 32'h0040_3008);
    chk("jal_pc", out_pc, 32'h0040_3000);
    drive(OP_LINK, 0, 0, 0); in_pc = 32'h0040_3000; flush = 1; step;
    chk("jal_flush", 32'(out_valid), 0);
    drive(OP_MULT, 32'hFFFF_FFFE, 3, 0); step;
    drive(OP_MFLO, 0, 0, 0); #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mul_stall%0d", i), 32'(stall_out), 1);
      step;
      if (i == 0) chk("mul_bubble", 32'(out_valid), 0);
    end
    chk("mul_stall_end", 32'(stall_out), 0);
    step;
    chk("mult_lo", out_result, 32'hFFFF_FFFA);
    chk("mult_lo_valid", 32'(out_valid), 1);
    drive(OP_MFHI, 0, 0, 0); step;
    chk("mult_hi", out_result, 32'hFFFF_FFFF);
    drive(OP_DIV, 32'hFFFF_FFF9, 2, 0); step;
    drive(OP_MFHI, 0, 0, 0); wait_free(n); step;
    chk("div_hi", out_result, 32'hFFFF_FFFF);
    drive(OP_MFLO, 0, 0, 0); step;
    chk("div_lo", out_result, 32'hFFFF_FFFD);
    drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0); step;
    drive(OP_MFLO, 0, 0, 0); wait_free(n); step;
    chk("divmin_lo", out_result, 32'h8000_0000);
    drive(OP_MFHI, 0, 0, 0); step;
    chk("divmin_hi", out_result, 32'h0);
    drive(OP_DIVU, 5, 0, 0); step;
    drive(OP_MFLO, 0, 0, 0); wait_free(n);
    chk("div0_stalls", n, 9);
    step;
    chk("div0_lo", out_result, 32'h8000_0000);
    drive(OP_MFHI, 0, 0, 0); step;
    chk("div0_hi", out_result, 32'h0);
    drive(OP_MTHI, 32'hABCD, 0, 0); step;
    drive(OP_MFHI, 0, 0, 0); step;
    chk("mthi", out_result, 32'hABCD);
    drive(OP_MTLO, 32'h1111, 0, 0); flush = 1; step;
    chk("mtlo_flush_valid", 32'(out_valid), 0);
    drive(OP_MFLO, 0, 0, 0); step;
    chk("mtlo_flushed", out_result, 32'h8000_0000);
    in_valid = 0; step;
    chk("invalid", 32'(out_valid), 0);
    drive(OP_DIV, 100, 7, 0); step;
    drive(OP_MFLO, 0, 0, 0); step; step;
    chk("pre_rst_stall", 32'(stall_out), 1);
    rst_n = 0; #1;
    chk("mid_rst_stall", 32'(stall_out), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_result", out_result, 0);
    @(negedge clk) rst_n = 1;
    drive(OP_MFHI, 0, 0, 0); step;
    chk("rst_hi", out_result, 0);
    drive(OP_MFLO, 0, 0, 0); step;
    chk("rst_lo", out_result, 0);
    chk("rst_lo_valid", 32'(out_valid), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
